// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, the load/store port, the shared memory port and
// the pipeline stall outputs of mem_port_arbiter. Names are seen from the
// arbiter: i_* flow into it, o_* flow out of it.
//
// Handshake: a requester raises *_req with its address/data and holds it
// until it sees the one-cycle *_valid pulse. A request that is still high
// in the cycle its own valid is high is not a new request. Once a
// transaction is granted, later changes to req/addr/data have no effect.
// A flushed fetch never produces o_if_valid.
interface mem_port_arbiter_if;
    // fetch port
    logic        i_if_req;
    logic [31:0] i_if_addr;
    logic        i_if_flush;
    logic [31:0] o_if_rdata;
    logic        o_if_valid;
    // load/store port
    logic        i_ls_req;
    logic        i_ls_wren;
    logic [31:0] i_ls_addr;
    logic [31:0] i_ls_wdata;
    logic [3:0]  i_ls_bmask;
    logic [31:0] o_ls_rdata;
    logic        o_ls_valid;
    // shared memory port
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_bmask;
    logic        o_mem_rden;
    logic        o_mem_wren;
    logic [31:0] i_mem_rdata;
    // pipeline stalls
    logic        o_stall_if;
    logic        o_stall_mem;

    modport slave (
        input  i_if_req, i_if_addr, i_if_flush,
        output o_if_rdata, o_if_valid,
        input  i_ls_req, i_ls_wren, i_ls_addr, i_ls_wdata, i_ls_bmask,
        output o_ls_rdata, o_ls_valid,
        output o_mem_addr, o_mem_wdata, o_mem_bmask, o_mem_rden, o_mem_wren,
        input  i_mem_rdata,
        output o_stall_if, o_stall_mem
    );

    modport master (
        output i_if_req, i_if_addr, i_if_flush,
        input  o_if_rdata, o_if_valid,
        output i_ls_req, i_ls_wren, i_ls_addr, i_ls_wdata, i_ls_bmask,
        input  o_ls_rdata, o_ls_valid,
        input  o_mem_addr, o_mem_wdata, o_mem_bmask, o_mem_rden, o_mem_wren,
        output i_mem_rdata,
        input  o_stall_if, o_stall_mem
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between an instruction fetch
// port and a load/store port. One transaction is in flight at a time:
// a command cycle with a one-cycle read or write strobe, MEM_LAT cycles of
// memory latency, then a one-cycle valid pulse on the owning port.
// Load/store normally wins contention; after STARVE_MAX consecutive
// load/store grants taken while a fetch was waiting, the fetch wins.
module mem_port_arbiter #(
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic                            i_clk,
    input  logic                            i_reset,
    mem_port_arbiter_if.slave               io_bus,
    output logic [1:0]                      o_dbg_state,
    output logic [$clog2(STARVE_MAX+1)-1:0] o_dbg_starve
);
    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BUSY_IF = 2'd1,
        S_BUSY_LS = 2'd2
    } state_t;

    state_t         r_state;
    logic [SW-1:0]  r_starve;
    logic [2:0]     r_cnt;
    logic [31:0]    r_mem_addr;
    logic [31:0]    r_mem_wdata;
    logic [3:0]     r_mem_bmask;
    logic           r_mem_rden;
    logic           r_mem_wren;
    logic           r_wr;
    logic           r_flushed;
    logic [31:0]    r_if_rdata;
    logic [31:0]    r_ls_rdata;
    logic           r_if_valid;
    logic           r_ls_valid;

    logic           w_if_qual;
    logic           w_ls_qual;
    logic           w_starved;
    logic           w_grant_if;
    logic           w_grant_ls;
    logic           w_sample;

    // A port whose valid is high this cycle is finishing, not asking again.
    assign w_if_qual  = io_bus.i_if_req & ~r_if_valid;
    assign w_ls_qual  = io_bus.i_ls_req & ~r_ls_valid;
    assign w_starved  = (r_starve == SW'(STARVE_MAX));
    assign w_grant_if = w_if_qual & (~w_ls_qual | w_starved);
    assign w_grant_ls = w_ls_qual & ~w_grant_if;
    // r_cnt is 0 in the command cycle; memory data is valid MEM_LAT later.
    assign w_sample   = (r_cnt == 3'(MEM_LAT));

    // Arbitration, command issue, latency counting and completion.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_starve    <= '0;
            r_cnt       <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_bmask <= '0;
            r_mem_rden  <= 1'b0;
            r_mem_wren  <= 1'b0;
            r_wr        <= 1'b0;
            r_flushed   <= 1'b0;
            r_if_rdata  <= '0;
            r_ls_rdata  <= '0;
            r_if_valid  <= 1'b0;
            r_ls_valid  <= 1'b0;
        end else begin
            r_if_valid <= 1'b0;
            r_ls_valid <= 1'b0;
            r_mem_rden <= 1'b0;
            r_mem_wren <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (w_grant_if) begin
                        r_state     <= S_BUSY_IF;
                        r_mem_addr  <= io_bus.i_if_addr;
                        r_mem_wdata <= '0;
                        r_mem_bmask <= 4'hF;
                        r_wr        <= 1'b0;
                        r_mem_rden  <= 1'b1;
                        r_flushed   <= 1'b0;
                        r_starve    <= '0;
                    end else if (w_grant_ls) begin
                        r_state     <= S_BUSY_LS;
                        r_mem_addr  <= io_bus.i_ls_addr;
                        r_mem_wdata <= io_bus.i_ls_wdata;
                        r_mem_bmask <= io_bus.i_ls_bmask;
                        r_wr        <= io_bus.i_ls_wren;
                        r_mem_rden  <= ~io_bus.i_ls_wren;
                        r_mem_wren  <= io_bus.i_ls_wren;
                        if (io_bus.i_if_req && !w_starved) begin
                            r_starve <= r_starve + 1'b1;
                        end
                    end
                end
                S_BUSY_IF: begin
                    if (io_bus.i_if_flush) begin
                        r_flushed <= 1'b1;
                    end
                    if (w_sample) begin
                        r_state <= S_IDLE;
                        // A flush seen in any cycle of the fetch, including
                        // this one, hides the result from the fetch stage.
                        if (!(r_flushed || io_bus.i_if_flush)) begin
                            r_if_rdata <= io_bus.i_mem_rdata;
                            r_if_valid <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_BUSY_LS: begin
                    if (w_sample) begin
                        r_state    <= S_IDLE;
                        r_ls_valid <= 1'b1;
                        if (!r_wr) begin
                            r_ls_rdata <= io_bus.i_mem_rdata;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign io_bus.o_if_rdata  = r_if_rdata;
    assign io_bus.o_if_valid  = r_if_valid;
    assign io_bus.o_ls_rdata  = r_ls_rdata;
    assign io_bus.o_ls_valid  = r_ls_valid;
    assign io_bus.o_mem_addr  = r_mem_addr;
    assign io_bus.o_mem_wdata = r_mem_wdata;
    assign io_bus.o_mem_bmask = r_mem_bmask;
    assign io_bus.o_mem_rden  = r_mem_rden;
    assign io_bus.o_mem_wren  = r_mem_wren;
    // Stalls follow the raw request so the stage freezes in the request cycle.
    assign io_bus.o_stall_if  = io_bus.i_if_req & ~r_if_valid;
    assign io_bus.o_stall_mem = io_bus.i_ls_req & ~r_ls_valid;

    assign o_dbg_state  = r_state;
    assign o_dbg_starve = r_starve;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by random traffic
// on a MEM_LAT=1 instance, compared every cycle against a transaction-level
// model, plus a directed load on a MEM_LAT=3 instance.
module tb_mem_port_arbiter;
  localparam int STARVE_MAX = 4;
  localparam int LAT_A      = 1;
  localparam int LAT_B      = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus_a();
  mem_port_arbiter_if bus_b();
  logic [1:0] dbg_state_a, dbg_state_b;
  logic [2:0] dbg_starve_a, dbg_starve_b;

  mem_port_arbiter #(.MEM_LAT(LAT_A), .STARVE_MAX(STARVE_MAX)) dut_a (
    .i_clk(clk), .i_reset(rst), .io_bus(bus_a.slave),
    .o_dbg_state(dbg_state_a), .o_dbg_starve(dbg_starve_a)
  );
  mem_port_arbiter #(.MEM_LAT(LAT_B), .STARVE_MAX(STARVE_MAX)) dut_b (
    .i_clk(clk), .i_reset(rst), .io_bus(bus_b.slave),
    .o_dbg_state(dbg_state_b), .o_dbg_starve(dbg_starve_b)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", tag, cyc, act, exp);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  // A granted transaction is described by its grant cycle; everything else
  // follows by arithmetic: command at grant+1, data taken at grant+1+LAT,
  // valid at grant+2+LAT.
  bit          m_busy;
  bit          m_port_if;
  int          m_grant;
  bit          m_wr;
  bit          m_flushed;
  int          m_starve;
  logic [31:0] e_addr, e_wdata, e_if_rdata, e_ls_rdata;
  logic [3:0]  e_bmask;
  bit          e_wdata_chk;
  int          e_rd_cyc, e_wr_cyc, e_if_vcyc, e_ls_vcyc;

  task automatic model_clear();
    m_busy = 0; m_port_if = 0; m_grant = -10; m_wr = 0; m_flushed = 0; m_starve = 0;
    e_addr = '0; e_wdata = '0; e_if_rdata = '0; e_ls_rdata = '0; e_bmask = '0;
    e_wdata_chk = 1; e_rd_cyc = -1; e_wr_cyc = -1; e_if_vcyc = -1; e_ls_vcyc = -1;
  endtask

  // Decide what the coming rising edge does, from the inputs of cycle cyc.
  task automatic model_edge();
    bit if_q, ls_q;
    if (rst) begin
      model_clear();
    end else if (m_busy) begin
      if (m_port_if && bus_a.i_if_flush) m_flushed = 1;
      if (cyc == m_grant + 1 + LAT_A) begin
        if (m_port_if) begin
          if (!m_flushed) begin
            e_if_rdata = bus_a.i_mem_rdata;
            e_if_vcyc  = cyc + 1;
          end
        end else begin
          if (!m_wr) e_ls_rdata = bus_a.i_mem_rdata;
          e_ls_vcyc = cyc + 1;
        end
        m_busy = 0;
      end
    end else begin
      if_q = bus_a.i_if_req && (cyc != e_if_vcyc);
      ls_q = bus_a.i_ls_req && (cyc != e_ls_vcyc);
      if (if_q && (!ls_q || m_starve == STARVE_MAX)) begin
        m_busy = 1; m_port_if = 1; m_grant = cyc; m_wr = 0; m_flushed = 0; m_starve = 0;
        e_addr = bus_a.i_if_addr; e_bmask = 4'hF; e_wdata_chk = 0; e_rd_cyc = cyc + 1;
      end else if (ls_q) begin
        m_busy = 1; m_port_if = 0; m_grant = cyc; m_wr = bus_a.i_ls_wren;
        e_addr = bus_a.i_ls_addr; e_bmask = bus_a.i_ls_bmask;
        e_wdata = bus_a.i_ls_wdata; e_wdata_chk = 1;
        if (m_wr) e_wr_cyc = cyc + 1; else e_rd_cyc = cyc + 1;
        if (bus_a.i_if_req && m_starve < STARVE_MAX) m_starve++;
      end
    end
  endtask

  task automatic check_outputs();
    logic [1:0] exp_state;
    exp_state = !m_busy ? 2'd0 : (m_port_if ? 2'd1 : 2'd2);
    check_eq("state",    dbg_state_a,          exp_state);
    check_eq("starve",   dbg_starve_a,         m_starve);
    check_eq("rden",     bus_a.o_mem_rden,     cyc == e_rd_cyc);
    check_eq("wren",     bus_a.o_mem_wren,     cyc == e_wr_cyc);
    check_eq("mem_addr", bus_a.o_mem_addr,     e_addr);
    check_eq("bmask",    bus_a.o_mem_bmask,    e_bmask);
    if (e_wdata_chk) check_eq("wdata", bus_a.o_mem_wdata, e_wdata);
    check_eq("if_valid", bus_a.o_if_valid,     cyc == e_if_vcyc);
    check_eq("ls_valid", bus_a.o_ls_valid,     cyc == e_ls_vcyc);
    check_eq("if_rdata", bus_a.o_if_rdata,     e_if_rdata);
    check_eq("ls_rdata", bus_a.o_ls_rdata,     e_ls_rdata);
  endtask

  // ---------------- driver ----------------
  // Called with the inputs of cycle cyc already applied (just after an edge).
  task automatic step();
    #1;
    check_eq("stall_if",  bus_a.o_stall_if,  bus_a.i_if_req && (cyc != e_if_vcyc));
    check_eq("stall_mem", bus_a.o_stall_mem, bus_a.i_ls_req && (cyc != e_ls_vcyc));
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
    check_outputs();
  endtask

  task automatic idle_inputs_a();
    bus_a.i_if_req = 0; bus_a.i_if_addr = '0; bus_a.i_if_flush = 0;
    bus_a.i_ls_req = 0; bus_a.i_ls_wren = 0; bus_a.i_ls_addr = '0;
    bus_a.i_ls_wdata = '0; bus_a.i_ls_bmask = '0; bus_a.i_mem_rdata = '0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int base, ls_cnt;
    bit seen;
    idle_inputs_a();
    bus_b.i_if_req = 0; bus_b.i_if_addr = '0; bus_b.i_if_flush = 0;
    bus_b.i_ls_req = 0; bus_b.i_ls_wren = 0; bus_b.i_ls_addr = '0;
    bus_b.i_ls_wdata = '0; bus_b.i_ls_bmask = '0; bus_b.i_mem_rdata = '0;
    model_clear();
    rst = 1;
    @(posedge clk); #1;
    step(); step();
    rst = 0;
    check_eq("reset_state", dbg_state_a, 2'd0);
    check_eq("reset_addr",  bus_a.o_mem_addr, 32'h0);

    // Fetch only
    bus_a.i_if_req = 1; bus_a.i_if_addr = 32'h100; bus_a.i_mem_rdata = 32'h0050_0093;
    base = cyc;
    step();
    check_eq("fetch_rden", bus_a.o_mem_rden, 1'b1);
    check_eq("fetch_addr", bus_a.o_mem_addr, 32'h100);
    step(); step();
    check_eq("fetch_valid", bus_a.o_if_valid, 1'b1);
    check_eq("fetch_rdata", bus_a.o_if_rdata, 32'h0050_0093);
    check_eq("fetch_lat",   cyc - base, 3);
    bus_a.i_if_req = 0;
    step();

    // Store
    bus_a.i_ls_req = 1; bus_a.i_ls_wren = 1; bus_a.i_ls_addr = 32'h2000;
    bus_a.i_ls_wdata = 32'hDEAD_BEEF; bus_a.i_ls_bmask = 4'b0011; bus_a.i_mem_rdata = 32'h1234_5678;
    step();
    check_eq("st_wren",  bus_a.o_mem_wren,  1'b1);
    check_eq("st_rden",  bus_a.o_mem_rden,  1'b0);
    check_eq("st_addr",  bus_a.o_mem_addr,  32'h2000);
    check_eq("st_wdata", bus_a.o_mem_wdata, 32'hDEAD_BEEF);
    check_eq("st_bmask", bus_a.o_mem_bmask, 4'b0011);
    step();
    check_eq("st_wren_once", bus_a.o_mem_wren, 1'b0);
    step();
    check_eq("st_valid", bus_a.o_ls_valid, 1'b1);
    check_eq("st_rdata_kept", bus_a.o_ls_rdata, 32'h0);
    bus_a.i_ls_req = 0; bus_a.i_ls_wren = 0;
    step();

    // Flush: fetch started, flush raised in its sample cycle
    bus_a.i_if_req = 1; bus_a.i_if_addr = 32'h140; bus_a.i_mem_rdata = 32'hCAFE_F00D;
    step();
    check_eq("fl_rden", bus_a.o_mem_rden, 1'b1);
    step();
    bus_a.i_if_flush = 1;
    step();
    check_eq("fl_no_valid", bus_a.o_if_valid, 1'b0);
    check_eq("fl_rdata_kept", bus_a.o_if_rdata, 32'h0050_0093);
    check_eq("fl_idle", dbg_state_a, 2'd0);
    bus_a.i_if_flush = 0; bus_a.i_if_req = 0;
    step();

    // Contention. The fetch request is withdrawn only in the load/store
    // completion cycle, where it would otherwise be the sole contender; in
    // every re-request cycle both ports compete.
    bus_a.i_if_req = 1; bus_a.i_if_addr = 32'h400;
    bus_a.i_ls_req = 1; bus_a.i_ls_wren = 0; bus_a.i_ls_addr = 32'h800; bus_a.i_ls_bmask = 4'hF;
    ls_cnt = 0; seen = 0;
    for (int i = 0; i < 80 && !seen; i++) begin
      bus_a.i_mem_rdata = $urandom;
      step();
      if (bus_a.o_mem_rden && bus_a.o_mem_addr == 32'h800) ls_cnt++;
      if (bus_a.o_mem_rden && bus_a.o_mem_addr == 32'h400) begin
        seen = 1;
        check_eq("cont_ls_grants", ls_cnt, 4);
        check_eq("cont_starve_clr", dbg_starve_a, 3'd0);
      end
      if (!seen) bus_a.i_if_req = !bus_a.o_ls_valid;
    end
    check_eq("cont_fetch_seen", seen, 1'b1);
    bus_a.i_ls_req = 0; bus_a.i_if_req = 1;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      if (bus_a.o_if_valid) begin seen = 1; bus_a.i_if_req = 0; end
    end
    check_eq("cont_fetch_done", seen, 1'b1);
    bus_a.i_if_req = 0;
    step();

    // Reset in the command cycle of a load
    bus_a.i_ls_req = 1; bus_a.i_ls_wren = 0; bus_a.i_ls_addr = 32'h500; bus_a.i_ls_bmask = 4'hF;
    step();
    check_eq("rl_rden", bus_a.o_mem_rden, 1'b1);
    rst = 1; bus_a.i_ls_req = 0;
    step();
    rst = 0;
    check_eq("rl_state",  dbg_state_a,        2'd0);
    check_eq("rl_rden0",  bus_a.o_mem_rden,   1'b0);
    check_eq("rl_addr0",  bus_a.o_mem_addr,   32'h0);
    check_eq("rl_bmask0", bus_a.o_mem_bmask,  4'h0);
    check_eq("rl_ifrd0",  bus_a.o_if_rdata,   32'h0);
    for (int i = 0; i < 4; i++) begin
      bus_a.i_mem_rdata = $urandom;
      step();
      check_eq("rl_no_valid", bus_a.o_ls_valid, 1'b0);
    end

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      rst = ($urandom_range(0, 249) == 0);
      bus_a.i_if_flush = 0;
      if (rst) begin
        bus_a.i_if_req = 0; bus_a.i_ls_req = 0;
      end else begin
        if (bus_a.i_if_req) begin
          if (bus_a.o_if_valid) bus_a.i_if_req = $urandom_range(0, 1);
          else if ($urandom_range(0, 15) == 0) begin bus_a.i_if_flush = 1; bus_a.i_if_req = 0; end
        end else begin
          bus_a.i_if_req = ($urandom_range(0, 2) == 0);
        end
        if (bus_a.i_ls_req) begin
          if (bus_a.o_ls_valid) bus_a.i_ls_req = $urandom_range(0, 1);
        end else begin
          bus_a.i_ls_req = ($urandom_range(0, 2) == 0);
        end
      end
      bus_a.i_if_addr  = $urandom & 32'h0000_FFFC;
      bus_a.i_ls_addr  = $urandom;
      bus_a.i_ls_wren  = $urandom_range(0, 1);
      bus_a.i_ls_wdata = $urandom;
      bus_a.i_ls_bmask = 4'($urandom_range(0, 15));
      bus_a.i_mem_rdata = $urandom;
      step();
    end
    rst = 0;
    idle_inputs_a();
    step();

    // MEM_LAT=3 instance: one load, request in cycle k=0
    bus_b.i_ls_req = 1; bus_b.i_ls_wren = 0; bus_b.i_ls_addr = 32'h3000; bus_b.i_ls_bmask = 4'hF;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) begin
        check_eq("l3_rden",  bus_b.o_mem_rden, k == 1);
        check_eq("l3_wren",  bus_b.o_mem_wren, 1'b0);
        check_eq("l3_valid", bus_b.o_ls_valid, k == 5);
        if (k >= 5) check_eq("l3_rdata", bus_b.o_ls_rdata, 32'hA000_0004);
        if (k == 6) check_eq("l3_idle", dbg_state_b, 2'd0);
        if (k == 5) bus_b.i_ls_req = 0;
      end
      bus_b.i_mem_rdata = 32'hA000_0000 + k;
      @(posedge clk); #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have parameter MEM_LAT, default 1, giving memory read latency in cycles after the command cycle (legal range 1..4).
REQ-002 The block SHALL have parameter STARVE_MAX, default 4, giving the number of consecutive data grants allowed while a fetch waits.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset, with these ports:
- i_clk  in  1  clock; all state changes on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_if_req  in  1  fetch request, held until o_if_valid
- i_if_addr  in  32  fetch byte address
- i_if_flush  in  1  discard the fetch in flight
- o_if_rdata  out  32  fetched instruction
- o_if_valid  out  1  one-cycle fetch completion pulse
- i_ls_req  in  1  load/store request, held until o_ls_valid
- i_ls_wren  in  1  1 = store, 0 = load
- i_ls_addr  in  32  data byte address
- i_ls_wdata  in  32  store data
- i_ls_bmask  in  4  store byte enables
- o_ls_rdata  out  32  load data
- o_ls_valid  out  1  one-cycle load/store completion pulse
- o_mem_addr  out  32  shared memory address
- o_mem_wdata  out  32  shared memory write data
- o_mem_bmask  out  4  shared memory byte enables
- o_mem_rden  out  1  memory read strobe
- o_mem_wren  out  1  memory write strobe
- i_mem_rdata  in  32  memory read data
- o_stall_if  out  1  freeze fetch stage
- o_stall_mem  out  1  freeze MEM stage and everything upstream

Function
REQ-004 The FSM SHALL have three states: IDLE, BUSY_IF and BUSY_LS.
REQ-005 In IDLE, a request SHALL be ignored in the same cycle its own valid output is high.
REQ-006 In IDLE with only one qualified request, the FSM SHALL move to that request's BUSY state on the next edge and register the address, data, byte mask and write flag.
REQ-007 In IDLE with both requests qualified, the load/store port SHALL win unless the starve counter equals STARVE_MAX; in that case the fetch port SHALL win.
REQ-008 The starve counter SHALL:
- increment on each load/store grant while i_if_req is high
- saturate at STARVE_MAX
- clear on every fetch grant
REQ-009 o_mem_rden or o_mem_wren SHALL be high for exactly the first cycle of a BUSY state (the command cycle), never both.
REQ-010 o_mem_addr, o_mem_wdata and o_mem_bmask SHALL hold the registered values for the whole BUSY state.
REQ-011 Fetches SHALL always be reads, with o_mem_bmask = 4'hF.
REQ-012 A cycle counter SHALL count from the command cycle; i_mem_rdata SHALL be sampled MEM_LAT cycles after the command cycle.
REQ-013 On the sample edge, the block SHALL load rdata into the granted port's rdata register, pulse that port's valid in the next cycle, and return to IDLE in that same cycle.
REQ-014 Total latency from request edge to valid SHALL be MEM_LAT+2 cycles (3 for the default).
REQ-015 Stores SHALL complete with the same timing as loads; o_ls_rdata SHALL stay unchanged on a store.
REQ-016 o_if_rdata and o_ls_rdata SHALL hold their last value until the next completion on the same port.
REQ-017 If i_if_flush is high in any BUSY_IF cycle, the transaction SHALL still run to completion on memory, but o_if_valid and the o_if_rdata update SHALL be suppressed.
REQ-018 A flushed fetch SHALL still return the FSM to IDLE on schedule.
REQ-019 The stall outputs SHALL be combinational:
- o_stall_if = i_if_req AND NOT o_if_valid
- o_stall_mem = i_ls_req AND NOT o_ls_valid
REQ-020 Requests SHALL be sampled only in IDLE; request and address changes during a BUSY state SHALL have no effect.

Reset
REQ-021 While i_reset is high at a rising edge, the block SHALL set state IDLE, starve counter 0, cycle counter 0 and every output register to 0, including rdata, valid, memory strobes, address, wdata and bmask.
REQ-022 A reset during a BUSY state SHALL abandon the transaction: no valid pulse afterwards, and late memory data ignored.
REQ-023 The first grant after reset SHALL occur no earlier than the first edge on which i_reset is low.

Verification
REQ-024 A bench SHALL cover these directed scenarios:
- Fetch only: i_if_req=1, i_if_addr=0x100, memory returns 0x00500093 -> o_mem_rden pulses at cycle 1 with addr 0x100; o_if_valid=1 and o_if_rdata=0x00500093 at cycle 3; o_stall_if high for cycles 0-2.
- Store: i_ls_req=1, i_ls_wren=1, addr 0x2000, wdata 0xDEADBEEF, bmask 4'b0011 -> o_mem_wren one cycle with those values; o_ls_valid at cycle 3; o_ls_rdata unchanged.
- Contention with STARVE_MAX=4: both requests held continuously, load/store re-requesting every completion -> 4 load/store grants, then 1 fetch grant, then the starve counter reads 0.
- Flush: start a fetch, assert i_if_flush at cycle 2 -> o_mem_rden still pulses; no o_if_valid; o_if_rdata keeps its previous value; FSM in IDLE at cycle 3.
- Reset mid-load: assert i_reset in the command cycle of a load -> next cycle all outputs 0 and state IDLE; no o_ls_valid even when i_mem_rdata arrives.
- MEM_LAT=3 build: single load -> o_ls_valid 5 cycles after the request edge; no overlapping memory strobes.
